mux_scan_sequencer: RTL

//  Upstream sequencer for an 8:1 select mux (e.g. mux_8to1_s7): drives sel, samples the mux output.
//  On start, walks sel 0..NUM_CH-1, waits SETTLE cycles per channel, captures mux_out into bit [sel].

---
 rtl/mux_scan_sequencer_if.sv | 30 +++
 rtl/mux_scan_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer_if.sv
// Word-delivery bus of the mux scan sequencer: assembled word with valid/ready handshake.
// Carries word_parity only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_sequencer_if #(
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0] word;
  logic              word_valid;
  logic              word_ready;
`ifdef MUX_SCAN_PARITY_EN
  logic              word_parity;
`endif

  modport master (
    output word,
    output word_valid,
`ifdef MUX_SCAN_PARITY_EN
    output word_parity,
`endif
    input  word_ready
  );

  modport slave (
    input  word,
    input  word_valid,
`ifdef MUX_SCAN_PARITY_EN
    input  word_parity,
`endif
    output word_ready
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks an 8:1 mux select, samples each channel after a settle window and presents the word.
// Optional word_parity output is enabled by defining MUX_SCAN_PARITY_EN.
//
// state   | meaning
// --------|-------------------------------------------------------------
// IDLE    | waiting for start
// SCAN    | stepping sel, settling, capturing mux_out into shadow[sel]
// PRESENT | word_valid high, holding word until word_ready
module mux_scan_sequencer #(
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [SEL_W-1:0]   sel,
  input  logic               mux_out,
  output logic               busy,
  mux_scan_sequencer_if.master wb
);

  localparam int               NUM_CH   = 2 ** SEL_W;
  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [SEL_W-1:0] SEL_LAST = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
    $error("mux_scan_sequencer: SETTLE=%0d outside 0..15", SETTLE);
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0]   word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SCAN;
          sel_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == SETTLE_C) begin
          // Last cycle of this channel's window: capture, then step or finish.
          cnt_d            = '0;
          shadow_d[sel_q]  = mux_out;
          if (sel_q != SEL_LAST) begin
            sel_d = sel_q + SEL_ONE;
          end else begin
            word_d  = shadow_d;
            sel_d   = '0;
            state_d = ST_PRESENT;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_PRESENT: begin
        if (wb.word_ready) begin
          if (start) begin
            state_d  = ST_SCAN;
            sel_d    = '0;
            cnt_d    = '0;
            shadow_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign sel           = sel_q;
  assign busy          = (state_q == ST_SCAN);
  assign wb.word       = word_q;
  assign wb.word_valid = (state_q == ST_PRESENT);

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = ^word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign wb.word_parity = parity_q;
`endif

endmodule
